// File: rtl/blink_monitor.sv
// Blink-signal monitor: measures constant-level run lengths of sig_in, flags lock and stuck.
// Define BLINK_MONITOR_SYNC_EN for a two-flop input synchronizer (default: single input register).
module blink_monitor #(
  parameter int CNT_W = 8,
  parameter int TOL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             stuck
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] MEASURE = 3'd2;
  localparam logic [2:0] LOCKED  = 3'd3;
  localparam logic [2:0] STUCK   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);

  logic             s_reg;
  logic             s_d_reg;
  logic             edge_det;
  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] prev_reg, prev_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             vld_reg, vld_next;
  logic             locked_reg, stuck_reg;
  logic [CNT_W:0]   run_diff;
  logic             run_match;

`ifdef BLINK_MONITOR_SYNC_EN
  logic meta_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= 1'b0;
      s_reg    <= 1'b0;
    end else begin
      meta_reg <= sig_in;
      s_reg    <= meta_reg;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_reg <= 1'b0;
    else      s_reg <= sig_in;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_d_reg <= 1'b0;
    else      s_d_reg <= s_reg;
  end

  assign edge_det = s_reg ^ s_d_reg;

  // Widened by one bit so the absolute difference never wraps.
  always_comb begin
    if (cnt_reg >= prev_reg) run_diff = {1'b0, cnt_reg} - {1'b0, prev_reg};
    else                     run_diff = {1'b0, prev_reg} - {1'b0, cnt_reg};
  end

  assign run_match = (run_diff <= TOL_W);

  always_comb begin
    state_next  = state_reg;
    prev_next   = prev_reg;
    period_next = period_reg;
    vld_next    = 1'b0;
    if (edge_det)               cnt_next = CNT_ONE;
    else if (cnt_reg == CNT_MAX) cnt_next = cnt_reg;
    else                        cnt_next = cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (edge_det) state_next = ARMED;
      end
      ARMED, MEASURE, LOCKED: begin
        // An edge on the saturating cycle is still a valid full-scale run.
        if (edge_det) begin
          vld_next    = 1'b1;
          period_next = cnt_reg;
          prev_next   = cnt_reg;
          if (state_reg == ARMED) state_next = MEASURE;
          else                    state_next = run_match ? LOCKED : MEASURE;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = STUCK;
        end
      end
      STUCK: begin
        if (edge_det) begin
          state_next = ARMED;
          prev_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      prev_reg   <= '0;
      period_reg <= '0;
      vld_reg    <= 1'b0;
      locked_reg <= 1'b0;
      stuck_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      prev_reg   <= prev_next;
      period_reg <= period_next;
      vld_reg    <= vld_next;
      locked_reg <= (state_next == LOCKED);
      stuck_reg  <= (state_next == STUCK);
    end
  end

  assign period     = period_reg;
  assign period_vld = vld_reg;
  assign locked     = locked_reg;
  assign stuck      = stuck_reg;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed self-checking bench for blink_monitor (CNT_W=8, TOL=1).
// Strobe latency follows the BLINK_MONITOR_SYNC_EN build option.
module tb_blink_monitor;

`ifdef BLINK_MONITOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic [7:0] period;
  logic       period_vld;
  logic       locked;
  logic       stuck;

  int total = 0;
  int bad   = 0;
  int since = 0;

  blink_monitor #(.CNT_W(8), .TOL(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .period     (period),
    .period_vld (period_vld),
    .locked     (locked),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Toggle sig_in 'gap' cycles after the previous toggle, then check the strobe and flags.
  task automatic edge_check(input string tag, input int gap, input int exp_vld,
                            input int exp_period, input int exp_locked);
    repeat (gap - since) @(negedge clk);
    sig_in = ~sig_in;
    repeat (LAT - 1) @(negedge clk);
    chk({tag, "_early"}, period_vld, 0);
    @(negedge clk);
    chk({tag, "_vld"}, period_vld, exp_vld);
    chk({tag, "_period"}, period, exp_period);
    chk({tag, "_locked"}, locked, exp_locked);
    chk({tag, "_stuck"}, stuck, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, period_vld, 0);
    $display("run %s: gap=%0d period=%0d locked=%0d", tag, gap, period, locked);
    since = LAT + 1;
  endtask

  initial begin
    rst    = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_vld", period_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_stuck", stuck, 0);
    rst   = 1'b1;
    since = 0;

    // First edge only arms; steady 128-cycle runs then lock on the second strobe.
    edge_check("arm", 5, 0, 0, 0);
    edge_check("r128a", 128, 1, 128, 0);
    edge_check("r128b", 128, 1, 128, 1);
    edge_check("r128c", 128, 1, 128, 1);

    // Tolerance boundary: diff 1 locks, diff 2 unlocks.
    edge_check("r100", 100, 1, 100, 0);
    edge_check("r101", 101, 1, 101, 1);
    edge_check("r103", 103, 1, 103, 0);
    edge_check("r104", 104, 1, 104, 1);

    // Full-scale runs are measurements, not stuck.
    edge_check("r255a", 255, 1, 255, 0);
    edge_check("r255b", 255, 1, 255, 1);

    // Hold the level: stuck once the counter saturates without an edge.
    repeat (LAT + 254 - since) @(negedge clk);
    chk("pre_stuck", stuck, 0);
    chk("pre_stuck_locked", locked, 1);
    @(negedge clk);
    chk("stuck_set", stuck, 1);
    chk("stuck_locked", locked, 0);
    chk("stuck_period", period, 255);
    chk("stuck_vld", period_vld, 0);
    $display("stuck: stuck=%0d locked=%0d period=%0d", stuck, locked, period);
    since = LAT + 255;
    edge_check("unstick", 300, 0, 255, 0);
    edge_check("r50a", 50, 1, 50, 0);
    edge_check("r50b", 50, 1, 50, 1);

    // Asynchronous reset mid-run while locked.
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_period", period, 0);
    chk("async_vld", period_vld, 0);
    chk("async_locked", locked, 0);
    chk("async_stuck", stuck, 0);
    $display("reset: period=%0d locked=%0d stuck=%0d", period, locked, stuck);
    @(negedge clk);
    rst    = 1'b1;
    sig_in = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("post_arm_vld", period_vld, 0);
    chk("post_arm_period", period, 0);
    chk("post_arm_locked", locked, 0);
    since = LAT;
    edge_check("post60a", 60, 1, 60, 0);
    edge_check("post60b", 60, 1, 60, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
